// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcode, result record and overflow-relevance helper shared by the ALU and its result buffer.
package alu_pkg;

   localparam int ALU_WIDTH = 32;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_t;

   typedef struct packed {
      alu_op_t                opcode;
      logic [ALU_WIDTH-1:0]   result;
      logic                   zero;
      logic                   overflow;
      logic                   negative;
   } alu_result_t;

   // Only the arithmetic opcodes produce a meaningful signed overflow.
   function automatic logic alu_op_has_overflow(alu_op_t op);
      return (op == ALU_ADD) || (op == ALU_SUB);
   endfunction

endpackage

// File: rtl/alu_result_buffer_if.sv
// rtl/alu_result_buffer_if.sv - ALU-result producer side and writeback consumer side of the result buffer.
interface alu_result_buffer_if
   import alu_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int TAG_WIDTH = 4
);

   logic                 in_valid;
   logic                 in_ready;
   alu_op_t              in_opcode;
   logic [TAG_WIDTH-1:0] in_tag;
   logic [WIDTH-1:0]     in_result;
   logic                 in_zero;
   logic                 in_overflow;
   logic                 in_negative;

   logic                 out_valid;
   logic                 out_ready;
   alu_op_t              out_opcode;
   logic [TAG_WIDTH-1:0] out_tag;
   logic [WIDTH-1:0]     out_result;
   logic                 out_zero;
   logic                 out_overflow;
   logic                 out_negative;

   modport slave (
      input  in_valid, in_opcode, in_tag, in_result, in_zero, in_overflow, in_negative,
      input  out_ready,
      output in_ready,
      output out_valid, out_opcode, out_tag, out_result, out_zero, out_overflow, out_negative
   );

   modport master (
      output in_valid, in_opcode, in_tag, in_result, in_zero, in_overflow, in_negative,
      output out_ready,
      input  in_ready,
      input  out_valid, out_opcode, out_tag, out_result, out_zero, out_overflow, out_negative
   );

endinterface

// File: rtl/fifo_fwft.sv
// rtl/fifo_fwft.sv - Generic first-word-fall-through queue with occupancy count.
module fifo_fwft #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           data_o,
   output logic                       valid_o,
   output logic                       ready_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   logic             push_ok;
   logic             pop_ok;

   // Full-ness comes from registered count only, so a pop never frees a slot in the same cycle.
   assign ready_o = (count_q != CW'(DEPTH));
   assign valid_o = (count_q != '0);
   assign push_ok = push_i && ready_o;
   assign pop_ok  = pop_i && valid_o;
   assign count_o = count_q;
   assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

   always_comb begin
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/alu_result_buffer.sv
// rtl/alu_result_buffer.sv - Queues ALU results for writeback; masks overflow, tracks sticky overflow and retired ops.
module alu_result_buffer
   import alu_pkg::*;
#(
   parameter int WIDTH     = ALU_WIDTH,
   parameter int DEPTH     = 4,
   parameter int TAG_WIDTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   alu_result_buffer_if.slave         bus,
   input  logic                       clear_sticky,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       sticky_overflow,
   output logic [15:0]                retired_count
);

   localparam int ENTRY_W = TAG_WIDTH + $bits(alu_result_t);

   alu_result_t          in_res;
   alu_result_t          out_res;
   logic [TAG_WIDTH-1:0] out_tag_w;
   logic [ENTRY_W-1:0]   fifo_rdata;
   logic                 fifo_valid;
   logic                 fifo_ready;
   logic                 push;
   logic                 pop;

   logic                 sticky_q;
   logic                 sticky_d;
   logic [15:0]          retired_q;
   logic [15:0]          retired_d;

   assign push = bus.in_valid && fifo_ready;
   assign pop  = fifo_valid && bus.out_ready;

   always_comb begin
      in_res          = '0;
      in_res.opcode   = bus.in_opcode;
      in_res.result   = bus.in_result;
      in_res.zero     = bus.in_zero;
      in_res.overflow = bus.in_overflow && alu_op_has_overflow(bus.in_opcode);
      in_res.negative = bus.in_negative;
   end

   fifo_fwft #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .data_i  ({bus.in_tag, in_res}),
      .pop_i   (pop),
      .data_o  (fifo_rdata),
      .valid_o (fifo_valid),
      .ready_o (fifo_ready),
      .count_o (count)
   );

   // The queue already zeroes its read data when empty, so out_* need no extra gating.
   assign {out_tag_w, out_res} = fifo_rdata;

   assign bus.in_ready     = fifo_ready;
   assign bus.out_valid    = fifo_valid;
   assign bus.out_opcode   = out_res.opcode;
   assign bus.out_tag      = out_tag_w;
   assign bus.out_result   = out_res.result;
   assign bus.out_zero     = out_res.zero;
   assign bus.out_overflow = out_res.overflow;
   assign bus.out_negative = out_res.negative;

   // A new overflow in the same cycle as a clear must not be lost.
   always_comb begin
      sticky_d = sticky_q;
      if (push && in_res.overflow) begin
         sticky_d = 1'b1;
      end else if (clear_sticky) begin
         sticky_d = 1'b0;
      end
   end

   always_comb begin
      retired_d = retired_q;
      if (pop) retired_d = retired_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_q  <= 1'b0;
         retired_q <= '0;
      end else begin
         sticky_q  <= sticky_d;
         retired_q <= retired_d;
      end
   end

   assign sticky_overflow = sticky_q;
   assign retired_count   = retired_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb/tb_alu_result_buffer.sv - Directed self-checking bench for alu_result_buffer.
module tb_alu_result_buffer;
   import alu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        clear_sticky;
   logic [2:0]  count;
   logic        sticky_overflow;
   logic [15:0] retired_count;

   int n_checks = 0;
   int n_err    = 0;

   alu_result_buffer_if #(.WIDTH(32), .TAG_WIDTH(4)) ifc ();

   alu_result_buffer #(.WIDTH(32), .DEPTH(4), .TAG_WIDTH(4)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .bus             (ifc),
      .clear_sticky    (clear_sticky),
      .count           (count),
      .sticky_overflow (sticky_overflow),
      .retired_count   (retired_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic offer(input alu_op_t op, input logic [3:0] tag, input logic [31:0] res,
                        input logic z, input logic o, input logic n);
      ifc.in_valid    = 1'b1;
      ifc.in_opcode   = op;
      ifc.in_tag      = tag;
      ifc.in_result   = res;
      ifc.in_zero     = z;
      ifc.in_overflow = o;
      ifc.in_negative = n;
   endtask

   initial begin
      logic [3:0] et;
      rst_n           = 1'b0;
      clear_sticky    = 1'b0;
      ifc.in_valid    = 1'b0;
      ifc.in_opcode   = ALU_ADD;
      ifc.in_tag      = '0;
      ifc.in_result   = '0;
      ifc.in_zero     = 1'b0;
      ifc.in_overflow = 1'b0;
      ifc.in_negative = 1'b0;
      ifc.out_ready   = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      chk("rst_in_ready",  32'(ifc.in_ready), 32'd1);
      chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
      chk("rst_count",     32'(count), 32'd0);
      chk("rst_out_result", ifc.out_result, 32'd0);
      chk("rst_sticky",    32'(sticky_overflow), 32'd0);
      chk("rst_retired",   32'(retired_count), 32'd0);

      // ADD 0x7FFFFFFF + 1 overflows into a negative result
      offer(ALU_ADD, 4'd3, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
      tick();
      ifc.in_valid = 1'b0;
      chk("add_out_valid",  32'(ifc.out_valid), 32'd1);
      chk("add_out_result", ifc.out_result, 32'h8000_0000);
      chk("add_out_ovf",    32'(ifc.out_overflow), 32'd1);
      chk("add_out_neg",    32'(ifc.out_negative), 32'd1);
      chk("add_out_tag",    32'(ifc.out_tag), 32'd3);
      chk("add_sticky",     32'(sticky_overflow), 32'd1);
      chk("add_count",      32'(count), 32'd1);
      tick();
      chk("add_hold_result", ifc.out_result, 32'h8000_0000);
      ifc.out_ready = 1'b1;
      tick();
      ifc.out_ready = 1'b0;
      chk("add_pop_retired", 32'(retired_count), 32'd1);
      chk("add_pop_valid",   32'(ifc.out_valid), 32'd0);
      clear_sticky = 1'b1;
      tick();
      clear_sticky = 1'b0;
      chk("clear_sticky", 32'(sticky_overflow), 32'd0);

      // Logical op with overflow forced high must not report overflow
      offer(ALU_AND, 4'd5, 32'h0000_000F, 1'b0, 1'b1, 1'b0);
      tick();
      ifc.in_valid = 1'b0;
      chk("and_out_ovf",    32'(ifc.out_overflow), 32'd0);
      chk("and_sticky",     32'(sticky_overflow), 32'd0);
      chk("and_out_opcode", 32'(ifc.out_opcode), 32'(ALU_AND));
      chk("and_out_result", ifc.out_result, 32'h0000_000F);
      ifc.out_ready = 1'b1;
      tick();
      ifc.out_ready = 1'b0;
      chk("and_retired", 32'(retired_count), 32'd2);

      // Fill to DEPTH with tags 0..3
      for (int i = 0; i < 4; i++) begin
         offer(ALU_OR, 4'(i), 32'(i * 17), 1'b0, 1'b0, 1'b0);
         tick();
      end
      chk("full_count",    32'(count), 32'd4);
      chk("full_in_ready", 32'(ifc.in_ready), 32'd0);
      offer(ALU_OR, 4'd9, 32'h0000_DEAD, 1'b0, 1'b0, 1'b0);
      ifc.out_ready = 1'b1;
      chk("drain_tag_0", 32'(ifc.out_tag), 32'd0);
      tick();
      ifc.in_valid = 1'b0;
      chk("full_pop_no_push_count", 32'(count), 32'd3);
      for (int i = 1; i < 4; i++) begin
         chk($sformatf("drain_tag_%0d", i), 32'(ifc.out_tag), 32'(i));
         chk($sformatf("drain_result_%0d", i), ifc.out_result, 32'(i * 17));
         tick();
      end
      ifc.out_ready = 1'b0;
      chk("drain_out_valid", 32'(ifc.out_valid), 32'd0);
      chk("drain_count",     32'(count), 32'd0);
      chk("drain_retired",   32'(retired_count), 32'd6);
      chk("drain_out_tag0",  32'(ifc.out_tag), 32'd0);

      // Steady streaming at count=2 across pointer wrap
      for (int j = 0; j < 2; j++) begin
         offer(ALU_XOR, 4'(10 + j), 32'h1000 + 32'(j), 1'b0, 1'b0, 1'b0);
         tick();
      end
      chk("stream_pre_count", 32'(count), 32'd2);
      ifc.out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         offer(ALU_XOR, 4'(12 + k), 32'h1000 + 32'(k + 2), 1'b0, 1'b0, 1'b0);
         et = 4'(10 + k);
         chk($sformatf("stream_tag_%0d", k), 32'(ifc.out_tag), 32'(et));
         chk($sformatf("stream_result_%0d", k), ifc.out_result, 32'h1000 + 32'(k));
         tick();
         chk($sformatf("stream_count_%0d", k), 32'(count), 32'd2);
      end
      ifc.in_valid = 1'b0;
      chk("stream_retired",  32'(retired_count), 32'd16);
      chk("stream_head_tag", 32'(ifc.out_tag), 32'd4);
      chk("stream_head_res", ifc.out_result, 32'h0000_100A);
      tick();
      tick();
      ifc.out_ready = 1'b0;
      chk("stream_end_count",   32'(count), 32'd0);
      chk("stream_end_retired", 32'(retired_count), 32'd18);

      // Overflow set and clear in the same cycle: set wins
      offer(ALU_SUB, 4'd7, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
      clear_sticky = 1'b1;
      tick();
      clear_sticky = 1'b0;
      chk("sub_clear_sticky", 32'(sticky_overflow), 32'd1);
      chk("sub_out_ovf",      32'(ifc.out_overflow), 32'd1);
      offer(ALU_ADD, 4'd8, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
      tick();
      ifc.in_valid = 1'b0;
      chk("pre_rst_count", 32'(count), 32'd2);

      // Asynchronous reset while clk is low
      rst_n = 1'b0;
      #1;
      chk("arst_count",      32'(count), 32'd0);
      chk("arst_out_valid",  32'(ifc.out_valid), 32'd0);
      chk("arst_retired",    32'(retired_count), 32'd0);
      chk("arst_sticky",     32'(sticky_overflow), 32'd0);
      chk("arst_in_ready",   32'(ifc.in_ready), 32'd1);
      chk("arst_out_result", ifc.out_result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("post_rst_valid", 32'(ifc.out_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_result_buffer.md
Name: alu_result_buffer

Overview:
- Downstream stage of the combinational ALU. Captures each ALU result, its flags, opcode and tag into a small first-word-fall-through (FWFT) queue.
- Presents the queued entries to the writeback/consumer side under valid/ready.
- Decouples ALU issue from consumer stalls.
- Keeps a sticky overflow status and a retired-operation counter for debug and status readout.

Parameters:
- WIDTH, 32, datapath width; must match the ALU WIDTH.
- DEPTH, 4, number of queue entries; power of two, >= 2.
- TAG_WIDTH, 4, width of the caller-supplied operation tag.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  ALU result offered.
- in_ready  out  1  buffer can accept an entry.
- in_opcode  in  alu_op_t  opcode that produced the result.
- in_tag  in  TAG_WIDTH  operation tag.
- in_result  in  WIDTH  ALU result.
- in_zero  in  1  ALU zero flag.
- in_overflow  in  1  ALU overflow flag.
- in_negative  in  1  ALU negative flag.
- out_valid  out  1  head entry present.
- out_ready  in  1  consumer accepts the head entry.
- out_opcode  out  alu_op_t  head opcode.
- out_tag  out  TAG_WIDTH  head tag.
- out_result  out  WIDTH  head result.
- out_zero  out  1  head zero flag.
- out_overflow  out  1  head masked overflow flag.
- out_negative  out  1  head negative flag.
- count  out  $clog2(DEPTH+1)  current occupancy.
- clear_sticky  in  1  clears sticky_overflow.
- sticky_overflow  out  1  set once any accepted entry carried masked overflow.
- retired_count  out  16  number of entries popped; wraps at 65535 -> 0.

Behaviour:
- Reset (async assert, sync-safe deassert): count=0, out_valid=0, in_ready=1, sticky_overflow=0, retired_count=0, all out_* data fields 0. Reset mid-operation discards all queued entries.
- push = in_valid && in_ready; pop = out_valid && out_ready.
- in_ready = (count != DEPTH), derived from registered state only, never from out_ready. When full, a same-cycle pop does not admit a push.
- FWFT: an entry pushed in cycle N is visible at out_* with out_valid=1 in cycle N+1. Latency is 1 cycle when empty.
- out_valid = (count != 0). When out_valid=0, all out_* data fields are driven 0.
- Simultaneous push and pop when 0<count<DEPTH: count unchanged; head advances; new entry appended.
- Read and write pointers are $clog2(DEPTH) bits and wrap naturally. count is tracked separately to distinguish full from empty.
- Overflow masking at push: stored overflow = in_overflow && (in_opcode is ALU_ADD or ALU_SUB). For all other opcodes it is stored as 0. zero and negative are stored unmodified.
- sticky_overflow is set on any push whose masked overflow is 1, and cleared by clear_sticky. If set and clear occur in the same cycle, set wins.
- retired_count increments by 1 on each pop. It is 16-bit modular.
- in_* are sampled only on push. Changes to in_* while in_valid=0 or in_ready=0 have no effect.
- Holding out_ready=0 keeps the head entry and all out_* stable.

Decomposition:
- alu_pkg gains the function alu_op_has_overflow(alu_op_t), returning 1 for ALU_ADD/ALU_SUB. It is shared with the ALU and this block.
- alu_pkg gains the packed struct alu_result_t {opcode, result, zero, overflow, negative}. The tag stays a separate field because its width is parameterised.
- One natural sub-module: fifo_fwft, a generic WIDTH/DEPTH FWFT queue with push/pop/count, storing packed {tag, alu_result_t}.
- The wrapper alu_result_buffer owns the masking, sticky and retired logic.

Test Plan:
- Reset then idle: in_ready=1, out_valid=0, count=0, out_result=0, sticky_overflow=0, retired_count=0.
- Single push of ADD 0x7FFFFFFF+1 (result 0x80000000, overflow=1, negative=1), tag=3, out_ready=0: next cycle out_valid=1, out_result=0x80000000, out_overflow=1, out_tag=3, sticky_overflow=1.
- Push an AND result with in_overflow=1 forced high: out_overflow=0 and sticky_overflow stays 0.
- Fill with 4 entries (tags 0..3) while out_ready=0: in_ready=0 at count=4. A 5th offer is ignored. Drain with out_ready=1: tags pop in order 0,1,2,3; retired_count=4; count=0.
- With count=2, hold in_valid=1 and out_ready=1 for 10 cycles: count stays 2, tags emerge in push order, pointers wrap without loss.
- Raise clear_sticky in the same cycle as an overflowing SUB push: sticky_overflow=1 afterwards. Assert rst_n=0 mid-stream: count=0, out_valid=0 immediately (async), retired_count=0.
